// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load type codes,
// default widths and the MEM/WB register bundle.
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 5;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;

    typedef struct packed {
        logic             valid;
        logic             regwr;
        logic             memtoreg;
        logic [2:0]       ltype;
        logic [WB_DW-1:0] alu;
        logic [WB_DW-1:0] mdata;
        logic [WB_AW-1:0] rw;
    } mem_wb_t;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Little-endian sub-word load extraction with sign/zero extension.
// Unknown load codes fall through to a full-word load.
module load_ext
    import wb_pkg::*;
#(
    parameter int DW = WB_DW
) (
    input  logic [2:0]    ltype,
    input  logic [1:0]    off,
    input  logic [DW-1:0] mdata,
    output logic [DW-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = mdata[8*off +: 8];
        lane_h = off[1] ? mdata[31:16] : mdata[15:0];
        data   = mdata;
        case (ltype)
            LT_LB:   data = {{(DW-8){lane_b[7]}}, lane_b};
            LT_LBU:  data = {{(DW-8){1'b0}}, lane_b};
            LT_LH:   data = {{(DW-16){lane_h[15]}}, lane_h};
            LT_LHU:  data = {{(DW-16){1'b0}}, lane_h};
            default: data = mdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, result mux, $0 write gate
// and retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Run,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          M_Valid,
    input  logic          M_RegWr,
    input  logic          M_MemToReg,
    input  logic [2:0]    M_LoadType,
    input  logic [DW-1:0] M_AluOut,
    input  logic [DW-1:0] M_MemData,
    input  logic [AW-1:0] M_Rw,
    output logic [AW-1:0] Rw,
    output logic          RegWr,
    output logic [DW-1:0] busW,
    output logic          W_Valid,
    output logic [31:0]   InstRetired
);

    mem_wb_t     wb;
    logic [31:0] retired;
    logic [DW-1:0] ext;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wb.valid    <= 1'b0;
            wb.regwr    <= 1'b0;
            wb.memtoreg <= 1'b0;
            wb.ltype    <= LT_LW;
            wb.alu      <= '0;
            wb.mdata    <= '0;
            wb.rw       <= '0;
        end else if (Run) begin
            if (Flush) begin
                wb.valid <= 1'b0;
                wb.regwr <= 1'b0;
            end else if (!Stall) begin
                wb.valid    <= M_Valid;
                wb.regwr    <= M_RegWr;
                wb.memtoreg <= M_MemToReg;
                wb.ltype    <= M_LoadType;
                wb.alu      <= M_AluOut;
                wb.mdata    <= M_MemData;
                wb.rw       <= M_Rw;
            end
        end
    end

    // The instruction in WB leaves on every running edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            retired <= '0;
        else if (Run && wb.valid)
            retired <= retired + 32'd1;
    end

    load_ext #(.DW(DW)) u_ext (
        .ltype (wb.ltype),
        .off   (wb.alu[1:0]),
        .mdata (wb.mdata),
        .data  (ext)
    );

    assign busW        = wb.memtoreg ? ext : wb.alu;
    assign RegWr       = wb.valid & wb.regwr & (wb.rw != '0);
    assign Rw          = wb.rw;
    assign W_Valid     = wb.valid;
    assign InstRetired = retired;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_stage;
    import wb_pkg::*;

    logic        Clk = 0;
    logic        Rst_n = 0;
    logic        Run = 1;
    logic        Stall = 0;
    logic        Flush = 0;
    logic        M_Valid = 0;
    logic        M_RegWr = 0;
    logic        M_MemToReg = 0;
    logic [2:0]  M_LoadType = LT_LW;
    logic [31:0] M_AluOut = 0;
    logic [31:0] M_MemData = 0;
    logic [4:0]  M_Rw = 0;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic        W_Valid;
    logic [31:0] InstRetired;

    int checks = 0;
    int errors = 0;

    wb_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Stall(Stall),
        .Flush(Flush), .M_Valid(M_Valid), .M_RegWr(M_RegWr),
        .M_MemToReg(M_MemToReg), .M_LoadType(M_LoadType),
        .M_AluOut(M_AluOut), .M_MemData(M_MemData), .M_Rw(M_Rw),
        .Rw(Rw), .RegWr(RegWr), .busW(busW), .W_Valid(W_Valid),
        .InstRetired(InstRetired)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // The controller must never stall a valid instruction in WB.
    always @(posedge Clk)
        if (Rst_n && Run && Stall)
            chk("stall_valid_wb", {31'd0, W_Valid}, 32'd0);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rwr, input logic m2r,
                         input logic [2:0] lt, input logic [31:0] alu,
                         input logic [31:0] md, input logic [4:0] rd);
        M_Valid = v; M_RegWr = rwr; M_MemToReg = m2r;
        M_LoadType = lt; M_AluOut = alu; M_MemData = md; M_Rw = rd;
    endtask

    initial begin
        #12;
        chk("rst_rw", {27'd0, Rw}, 0);
        chk("rst_regwr", {31'd0, RegWr}, 0);
        chk("rst_busw", busW, 0);
        chk("rst_wvalid", {31'd0, W_Valid}, 0);
        chk("rst_cnt", InstRetired, 0);
        @(negedge Clk);
        Rst_n = 1;
        tick(); tick();
        chk("idle_regwr", {31'd0, RegWr}, 0);
        chk("idle_cnt", InstRetired, 0);

        drive(1, 1, 1, LT_LB, 32'h0000_1001, 32'h1234_80FF, 5'd5);
        tick();
        chk("lb_busw", busW, 32'hFFFF_FF80);
        chk("lb_regwr", {31'd0, RegWr}, 1);
        chk("lb_rw", {27'd0, Rw}, 5);
        chk("lb_cnt", InstRetired, 0);

        drive(1, 1, 1, LT_LBU, 32'h0000_1001, 32'h1234_80FF, 5'd6);
        tick();
        chk("lbu_busw", busW, 32'h0000_0080);
        chk("lbu_cnt", InstRetired, 1);

        drive(1, 1, 1, LT_LH, 32'h0000_2002, 32'h8001_0000, 5'd7);
        tick();
        chk("lh_busw", busW, 32'hFFFF_8001);

        drive(1, 1, 1, LT_LHU, 32'h0000_2002, 32'h8001_0000, 5'd7);
        tick();
        chk("lhu_busw", busW, 32'h0000_8001);

        drive(1, 1, 1, LT_LW, 32'h0000_2003, 32'hCAFE_BABE, 5'd8);
        tick();
        chk("lw_busw", busW, 32'hCAFE_BABE);
        chk("lw_cnt", InstRetired, 4);

        drive(1, 1, 0, LT_LW, 32'h0000_DEAD, 32'h0, 5'd0);
        tick();
        chk("r0_regwr", {31'd0, RegWr}, 0);
        chk("r0_wvalid", {31'd0, W_Valid}, 1);
        chk("r0_busw", busW, 32'h0000_DEAD);
        chk("r0_cnt_before", InstRetired, 5);

        drive(0, 0, 0, LT_LW, 32'h0000_0055, 32'h0, 5'd7);
        tick();
        chk("r0_cnt_after", InstRetired, 6);

        drive(1, 1, 0, LT_LW, 32'h0000_AAAA, 32'h0, 5'd9);
        Stall = 1;
        tick();
        chk("stall_busw", busW, 32'h0000_0055);
        chk("stall_rw", {27'd0, Rw}, 7);
        chk("stall_wvalid", {31'd0, W_Valid}, 0);

        Flush = 1;
        tick();
        chk("flush_wvalid", {31'd0, W_Valid}, 0);
        chk("flush_regwr", {31'd0, RegWr}, 0);
        chk("flush_cnt", InstRetired, 6);
        Flush = 0; Stall = 0;

        drive(1, 1, 0, LT_LW, 32'h0000_0077, 32'h0, 5'd3);
        tick();
        chk("pre_run_busw", busW, 32'h0000_0077);
        Run = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, LT_LB, 32'h100 + i, 32'hFFFF_FFFF, 5'd9);
            tick();
        end
        chk("frz_busw", busW, 32'h0000_0077);
        chk("frz_rw", {27'd0, Rw}, 3);
        chk("frz_regwr", {31'd0, RegWr}, 1);
        chk("frz_cnt", InstRetired, 6);
        Run = 1;

        drive(1, 1, 0, LT_LW, 32'h0000_0099, 32'h0, 5'd4);
        tick();
        chk("run_cnt", InstRetired, 7);
        dut.retired <= 32'hFFFF_FFFF;
        #1;
        chk("preload_cnt", InstRetired, 32'hFFFF_FFFF);
        drive(0, 0, 0, LT_LW, 32'h0, 32'h0, 5'd0);
        tick();
        chk("wrap_cnt", InstRetired, 0);

        drive(1, 1, 0, LT_LW, 32'h0000_0123, 32'h0, 5'd2);
        tick();
        chk("mid_regwr_pre", {31'd0, RegWr}, 1);
        #2;
        Rst_n = 0;
        #1;
        chk("mid_rst_regwr", {31'd0, RegWr}, 0);
        chk("mid_rst_cnt", InstRetired, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
